// File: rtl/fetch_pkg.sv
// Shared fetch-path defaults and the prefetch-queue entry layout.
package fetch_pkg;

    localparam int FETCH_ADDR_W   = 8;
    localparam int FETCH_DATA_W   = 32;
    localparam int FETCH_PC_INC   = 4;
    localparam int FETCH_RESET_PC = 0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of DEPTH entries with synchronous flush.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: caller must never push when full; flush wins over push.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 head_dat,
    output logic                         head_vld,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !flush;
    assign do_pop   = pop && (count != '0);
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests feeding a prefetch queue.
// Latency: response enters the queue on rvalid and is at the head one cycle later.
// Backpressure: requests stop while queue plus in-flight would exceed DEPTH.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int DATA_W   = FETCH_DATA_W,
    parameter int DEPTH    = 4,
    parameter int PC_INC   = FETCH_PC_INC,
    parameter int RESET_PC = FETCH_RESET_PC
) (
    input  logic                        clk_CPU,
    input  logic                        rst_n_CPU,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic                        imem_gnt,
    input  logic                        imem_rvalid,
    input  logic [DATA_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_instr,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [ADDR_W-1:0]           out_next_pc,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int                CNT_W      = $clog2(DEPTH+1);
    localparam int                ENT_W      = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(PC_INC - 1));

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              discard;
    logic [CNT_W:0]    occupancy;
    logic              grant;
    logic              rsp_done;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head_dat;
    logic              head_vld;
    logic [ADDR_W-1:0] head_pc;

    // The in-flight request already owns a queue slot, so it counts as occupancy.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    assign imem_req  = rst_n_CPU && (!outstanding || imem_rvalid)
                       && (occupancy < (CNT_W+1)'(DEPTH)) && !redirect_valid;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign rsp_done  = imem_rvalid && outstanding;
    assign push      = rsp_done && !discard && !redirect_valid;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk_CPU or negedge rst_n_CPU) begin
        if (!rst_n_CPU) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ALIGN_MASK;
            // A response landing in the redirect cycle is the stale one; drop it now.
            if (outstanding && !imem_rvalid) begin
                discard <= 1'b1;
            end else begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
        end else begin
            if (rsp_done) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (grant) begin
                outstanding <= 1'b1;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + INC;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_queue (
        .clk      (clk_CPU),
        .rst_n    (rst_n_CPU),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat ({req_pc, imem_rdata}),
        .pop      (pop),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .count    (count)
    );

    assign head_pc     = head_dat[ENT_W-1:DATA_W];
    assign out_valid   = head_vld;
    assign out_pc      = head_vld ? head_pc : '0;
    assign out_instr   = head_vld ? head_dat[DATA_W-1:0] : '0;
    assign out_next_pc = head_vld ? head_pc + INC : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic [7:0]  out_next_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    fetch_entry_t q[$];
    logic [7:0]   m_pc;
    logic [7:0]   m_oaddr;
    logic         m_out;
    logic         m_disc;
    int           n_pops;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk_CPU        (clk),
        .rst_n_CPU      (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_next_pc    (out_next_pc),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = 8'h00;
        m_out  = 1'b0;
        m_disc = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"},   imem_req,    1'b0);
        check({tag, "_vld"},   out_valid,   1'b0);
        check({tag, "_cnt"},   count,       3'd0);
        check({tag, "_instr"}, out_instr,   32'h0);
        check({tag, "_pc"},    out_pc,      8'h0);
        check({tag, "_npc"},   out_next_pc, 8'h0);
    endtask

    // One clock of stimulus; checks DUT outputs against the model, then advances the model.
    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdr, input logic [7:0] rpc, input logic rdy);
        logic         exp_req;
        logic         exp_vld;
        fetch_entry_t h;
        @(negedge clk);
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        exp_vld = (q.size() != 0);
        check("count", count, 64'(q.size()));
        check("out_valid", out_valid, exp_vld);
        if (exp_vld) begin
            h = q[0];
            check("out_pc", out_pc, h.pc);
            check("out_instr", out_instr, h.instr);
            check("out_next_pc", out_next_pc, 8'(h.pc + 8'd4));
        end else begin
            check("out_pc_idle", out_pc, 8'h0);
            check("out_instr_idle", out_instr, 32'h0);
            check("out_next_pc_idle", out_next_pc, 8'h0);
        end
        exp_req = (!m_out || rv) && ((q.size() + int'(m_out)) < DEPTH) && !rdr;
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_pc);

        if (exp_vld && rdy) begin
            void'(q.pop_front());
            n_pops++;
        end
        if (rdr) begin
            q.delete();
            m_pc = rpc & 8'hFC;
            if (m_out && rv) begin
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            if (rv && m_out) begin
                if (!m_disc) q.push_back('{pc: m_oaddr, instr: rd});
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
            if (exp_req && g) begin
                m_out   = 1'b1;
                m_oaddr = m_pc;
                m_pc    = m_pc + 8'd4;
            end
        end
    endtask

    task automatic release_reset(input logic stray_rv);
        @(negedge clk);
        rst_n          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = stray_rv;
        imem_rdata     = 32'hDEADBEEF;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 8'h00);
        check("first_cnt", count, 3'd0);
    endtask

    initial begin
        int hs;
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        n_pops = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("rst");
        release_reset(1'b0);

        // First fetch: grant at 0x00, response one cycle later.
        step(1, 0, 32'h0, 0, 8'h0, 0);
        check("r42_addr", imem_addr, 8'h00);
        step(0, 1, 32'h20080005, 0, 8'h0, 0);
        step(0, 0, 32'h0, 0, 8'h0, 0);
        check("r42_vld", out_valid, 1'b1);
        check("r42_pc", out_pc, 8'h00);
        check("r42_npc", out_next_pc, 8'h04);
        check("r42_instr", out_instr, 32'h20080005);

        // Decode stalled: fetch stops at DEPTH entries.
        for (int i = 0; i < 12; i++) step(1, m_out, $urandom, 0, 8'h0, 0);
        check("r43_cnt", count, 3'd4);
        check("r43_req", imem_req, 1'b0);
        step(1, 0, 32'h0, 0, 8'h0, 1);
        step(1, 0, 32'h0, 0, 8'h0, 0);
        check("r43_req_after_pop", imem_req, 1'b1);
        check("r43_addr", imem_addr, 8'h10);

        // Redirect with the 0x10 request outstanding.
        step(0, 0, 32'h0, 1, 8'h43, 0);
        step(0, 0, 32'h0, 0, 8'h0, 0);
        check("r44_cnt", count, 3'd0);
        step(0, 1, 32'hBADBAD00, 0, 8'h0, 0);
        check("r44_addr", imem_addr, 8'h40);
        step(0, 0, 32'h0, 0, 8'h0, 0);
        check("r44_stale_dropped", count, 3'd0);

        // Address wrap at the top of the 8-bit space.
        step(0, 0, 32'h0, 1, 8'hFC, 0);
        step(1, 0, 32'h0, 0, 8'h0, 0);
        check("r45_addr_fc", imem_addr, 8'hFC);
        step(0, 1, 32'h12345678, 0, 8'h0, 0);
        check("r45_wrap_addr", imem_addr, 8'h00);
        step(0, 0, 32'h0, 0, 8'h0, 0);
        check("r45_pc", out_pc, 8'hFC);
        check("r45_npc", out_next_pc, 8'h00);
        step(0, 0, 32'h0, 0, 8'h0, 1);

        // Streaming at full rate.
        hs = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, m_out, $urandom, 0, 8'h0, 1);
            check("r46_cnt_le1", 64'(count <= 3'd1), 1);
            if (i >= 4 && i < 20) begin
                check("r46_vld", out_valid, 1'b1);
                if (out_valid) hs++;
            end
        end
        check("r46_handshakes", hs, 16);

        // Reset with a full queue and a response in flight.
        for (int i = 0; i < 12; i++) step(1, m_out, $urandom, 0, 8'h0, 0);
        check("r47_full", count, 3'd4);
        @(negedge clk);
        rst_n = 1'b0;
        imem_rvalid = 1'b1;
        #1;
        check_zero_outputs("r47_async");
        model_reset();
        @(negedge clk);
        #1;
        check_zero_outputs("r47_hold");
        release_reset(1'b1);
        step(0, 1, 32'hCAFEF00D, 0, 8'h0, 0);
        step(0, 0, 32'h0, 0, 8'h0, 0);
        check("r47_stray_ignored", count, 3'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic g, rv, rdr, rdy;
            g   = ($urandom % 10) < 7;
            rdr = ($urandom % 20) == 0;
            rv  = m_out ? (($urandom % 10) < 6) : (($urandom % 25) == 0);
            rdy = ($urandom % 10) < 6;
            step(g, rv, $urandom, rdr, 8'($urandom), rdy);
        end
        check("rand_pops_seen", 64'(n_pops > 50), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
